uart_sram_tx_interface: RTL and testbench



---
 rtl/uart_sram_tx_interface_pkg.sv | 27 ++
 rtl/uart_tx_byte.sv | 103 ++++++++++
 rtl/uart_sram_tx_interface.sv | 153 +++++++++++++++
 tb/tb_uart_sram_tx_interface.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sram_tx_interface_pkg.sv
// rtl/uart_sram_tx_interface_pkg.sv - shared types and constants for the SRAM-to-UART transmit path
//
// Purpose: state enums for the transmit control FSM and the byte serializer,
// plus the default baud divider for a 50 MHz clock at 115200 baud.
// Ports: none (package).
package uart_sram_tx_interface_pkg;

    localparam int UART_BAUD_DIV_115200 = 434;
    localparam int SRAM_READ_LATENCY    = 2;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_READ,
        S_TX_WAIT,
        S_TX_SEND_HI,
        S_TX_SEND_LO,
        S_TX_FINISH
    } tx_state_type;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_tx_state_type;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with a valid/ready byte handshake
//
// Purpose: sends one byte as start(0), 8 data bits LSB first, stop(1); each
// bit is held BAUD_DIV cycles. Requires BAUD_DIV >= 2.
// Ports:
//   CLOCK_50_I  in   clock
//   resetn      in   asynchronous active-low reset
//   byte_data   in   byte to send, captured on handshake
//   byte_valid  in   byte_data is valid
//   byte_ready  out  serializer can accept a byte (S_IDLE only)
//   UART_TX_O   out  serial line, idle high
module uart_tx_byte
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_115200
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       UART_TX_O
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    // The stop bit's final cycle is spent in S_IDLE, where the next byte can
    // be accepted, so back-to-back frames have no idle gap on the line.
    localparam logic [CW-1:0] STOP_LAST = CW'(BAUD_DIV - 2);

    uart_tx_state_type state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (byte_valid) begin
                    state_d = S_START;
                    shift_d = byte_data;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready = (state_q == S_IDLE);
    assign UART_TX_O  = tx_q;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// rtl/uart_sram_tx_interface.sv - streams a block of 16-bit SRAM words out as UART bytes, high byte first
//
// Purpose: on Start, reads Word_count words from SRAM beginning at
// Start_address (18-bit wrapping) and sends each as two 8N1 frames.
// Ports:
//   CLOCK_50_I      in   clock
//   resetn          in   asynchronous active-low reset
//   Start           in   one-cycle start pulse (ignored while busy)
//   Start_address   in   first word address, sampled on Start
//   Word_count      in   number of words, sampled on Start
//   SRAM_address    out  SRAM word address
//   SRAM_we_n       out  constant 1 (read only)
//   SRAM_read_data  in   SRAM read data, READ_LATENCY cycles after address
//   UART_TX_O       out  serial line, idle high
//   Busy            out  transfer in progress
//   Done            out  one-cycle pulse at end of transfer
module uart_sram_tx_interface
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int BAUD_DIV     = UART_BAUD_DIV_115200,
    parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        Start,
    input  logic [17:0] Start_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY - 1);

    tx_state_type  state_q, state_d;
    logic [17:0]   addr_q, addr_d;
    logic [17:0]   rem_q, rem_d;
    logic [15:0]   word_q, word_d;
    logic [WW-1:0] wait_q, wait_d;
    // Set once the final low byte is handed over; the FSM then only waits for
    // the serializer to finish that frame.
    logic          sent_q, sent_d;

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_TX_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            wait_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        word_d     = word_q;
        wait_d     = wait_q;
        sent_d     = sent_q;
        byte_data  = word_q[15:8];
        byte_valid = 1'b0;
        case (state_q)
            S_TX_IDLE: begin
                if (Start) begin
                    rem_d  = Word_count;
                    sent_d = 1'b0;
                    if (Word_count == 18'd0) begin
                        state_d = S_TX_FINISH;
                    end else begin
                        // Address register updates on the edge into READ so it
                        // is already valid during the READ cycle.
                        addr_d  = Start_address;
                        state_d = S_TX_READ;
                    end
                end
            end
            S_TX_READ: begin
                wait_d  = '0;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    word_d  = SRAM_read_data;
                    state_d = S_TX_SEND_HI;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_TX_SEND_HI: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    state_d = S_TX_SEND_LO;
                end
            end
            S_TX_SEND_LO: begin
                byte_data = word_q[7:0];
                if (!sent_q) begin
                    byte_valid = 1'b1;
                    if (byte_ready) begin
                        rem_d = rem_q - 18'd1;
                        if (rem_q == 18'd1) begin
                            sent_d = 1'b1;
                        end else begin
                            // Next read overlaps the low-byte frame.
                            addr_d  = addr_q + 18'd1;
                            state_d = S_TX_READ;
                        end
                    end
                end else if (byte_ready) begin
                    state_d = S_TX_FINISH;
                end
            end
            S_TX_FINISH: begin
                state_d = S_TX_IDLE;
            end
            default: state_d = S_TX_IDLE;
        endcase
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .UART_TX_O  (UART_TX_O)
    );

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign Busy         = (state_q != S_TX_IDLE) && (state_q != S_TX_FINISH);
    assign Done         = (state_q == S_TX_FINISH);

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// tb/tb_uart_sram_tx_interface.sv - directed self-checking bench for uart_sram_tx_interface
module tb_uart_sram_tx_interface;

    localparam int BD = 4;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn     = 1'b0;
    logic        Start      = 1'b0;
    logic [17:0] Start_address = '0;
    logic [17:0] Word_count    = '0;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data = '0;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int done_cnt = 0, low_cnt = 0, busy_cnt = 0, wen_low_cnt = 0;
    logic [15:0] mem [0:262143];
    logic [15:0] pipe1 = '0;
    logic [17:0] addr_log [$];
    logic [17:0] last_addr = '0;

    uart_sram_tx_interface #(.BAUD_DIV(BD), .READ_LATENCY(2)) dut (
        .CLOCK_50_I     (CLOCK_50_I),
        .resetn         (resetn),
        .Start          (Start),
        .Start_address  (Start_address),
        .Word_count     (Word_count),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .UART_TX_O      (UART_TX_O),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    // Two-cycle SRAM read model and address-change log.
    always @(posedge CLOCK_50_I) begin
        cyc <= cyc + 1;
        pipe1 <= mem[SRAM_address];
        SRAM_read_data <= pipe1;
        if (resetn && SRAM_address !== last_addr) addr_log.push_back(SRAM_address);
        last_addr <= SRAM_address;
    end

    always @(negedge CLOCK_50_I) begin
        if (Done === 1'b1) done_cnt <= done_cnt + 1;
        if (UART_TX_O !== 1'b1) low_cnt <= low_cnt + 1;
        if (Busy !== 1'b0) busy_cnt <= busy_cnt + 1;
        if (SRAM_we_n !== 1'b1) wen_low_cnt <= wen_low_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [17:0] a, input logic [17:0] n, output int t);
        @(negedge CLOCK_50_I);
        Start_address = a;
        Word_count    = n;
        Start         = 1'b1;
        t             = cyc;
        @(negedge CLOCK_50_I);
        Start = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int t_start);
        int n;
        n = 0;
        b = '0;
        @(negedge CLOCK_50_I);
        while (UART_TX_O !== 1'b0 && n < 2000) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        chk("rx_start_seen", {31'd0, UART_TX_O}, 32'd0);
        t_start = cyc;
        repeat (BD / 2) @(negedge CLOCK_50_I);
        chk("rx_start_bit", {31'd0, UART_TX_O}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge CLOCK_50_I);
            b[i] = UART_TX_O;
        end
        repeat (BD) @(negedge CLOCK_50_I);
        chk("rx_stop_bit", {31'd0, UART_TX_O}, 32'd1);
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        @(negedge CLOCK_50_I);
        while (Done !== 1'b1 && n < 2000) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        chk("done_seen", {31'd0, Done}, 32'd1);
        t = cyc;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_bytes [6];
        int t0, t1, td, d0, l0, b0, w0;
        int ts [6];

        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        mem[18'h00010] = 16'hA55A;
        mem[18'h00020] = 16'hC33C;
        mem[18'h3FFFE] = 16'h1122;
        mem[18'h3FFFF] = 16'h3344;
        mem[18'h00000] = 16'h5566;
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55; exp_bytes[5] = 8'h66;

        // Reset values and 100 idle cycles.
        repeat (3) @(negedge CLOCK_50_I);
        chk("rst_tx", {31'd0, UART_TX_O}, 32'd1);
        chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        resetn = 1'b1;
        d0 = done_cnt; l0 = low_cnt; b0 = busy_cnt; w0 = wen_low_cnt;
        repeat (100) @(negedge CLOCK_50_I);
        chk("idle_line_low", low_cnt - l0, 0);
        chk("idle_busy", busy_cnt - b0, 0);
        chk("idle_done", done_cnt - d0, 0);
        chk("idle_we_n", wen_low_cnt - w0, 0);

        // One word 0xA55A from 0x00010.
        d0 = done_cnt;
        do_start(18'h00010, 18'd1, t0);
        chk("busy_after_start", {31'd0, Busy}, 32'd1);
        rx_byte(b, t1);
        chk("w1_latency", t1 - t0, 5);
        chk("w1_hi", {24'd0, b}, 32'hA5);
        rx_byte(b, td);
        chk("w1_lo", {24'd0, b}, 32'h5A);
        chk("w1_gap", td - t1, 10 * BD);
        wait_done(td);
        chk("w1_done_time", td - t1, 80);
        repeat (20) @(negedge CLOCK_50_I);
        chk("w1_done_once", done_cnt - d0, 1);
        chk("w1_busy_end", {31'd0, Busy}, 32'd0);

        // Three words across the address wrap, no gaps between frames.
        addr_log.delete();
        do_start(18'h3FFFE, 18'd3, t0);
        for (int i = 0; i < 6; i++) begin
            rx_byte(b, ts[i]);
            chk("wrap_byte", {24'd0, b}, {24'd0, exp_bytes[i]});
            if (i > 0) chk("wrap_gap", ts[i] - ts[i-1], 10 * BD);
        end
        wait_done(td);
        chk("wrap_done_time", td - ts[0], 240);
        chk("wrap_addr_n", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("wrap_addr0", {14'd0, addr_log[0]}, 32'h3FFFE);
            chk("wrap_addr1", {14'd0, addr_log[1]}, 32'h3FFFF);
            chk("wrap_addr2", {14'd0, addr_log[2]}, 32'h00000);
        end

        // Word_count = 0.
        repeat (5) @(negedge CLOCK_50_I);
        l0 = low_cnt; d0 = done_cnt;
        do_start(18'h00010, 18'd0, t0);
        if (Done === 1'b1) td = cyc; else wait_done(td);
        chk("zero_done_latency", {31'd0, (td - t0 >= 1) && (td - t0 <= 2)}, 32'd1);
        repeat (50) @(negedge CLOCK_50_I);
        chk("zero_line_high", low_cnt - l0, 0);
        chk("zero_done_once", done_cnt - d0, 1);

        // Second Start while busy is ignored.
        d0 = done_cnt;
        do_start(18'h00020, 18'd1, t0);
        Start_address = 18'h00010;
        Word_count    = 18'd5;
        Start         = 1'b1;
        @(negedge CLOCK_50_I);
        Start = 1'b0;
        rx_byte(b, t1);
        chk("ign_hi", {24'd0, b}, 32'hC3);
        chk("ign_latency", t1 - t0, 5);
        rx_byte(b, td);
        chk("ign_lo", {24'd0, b}, 32'h3C);
        wait_done(td);
        chk("ign_done_time", td - t1, 80);
        l0 = low_cnt;
        repeat (100) @(negedge CLOCK_50_I);
        chk("ign_no_more_bytes", low_cnt - l0, 0);
        chk("ign_done_once", done_cnt - d0, 1);

        // Reset in the middle of a data bit (bit 1 of 0xA5 is 0).
        do_start(18'h00010, 18'd1, t0);
        while (cyc < t0 + 14) @(negedge CLOCK_50_I);
        chk("mid_bit_low", {31'd0, UART_TX_O}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("abort_tx_high", {31'd0, UART_TX_O}, 32'd1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        repeat (3) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        do_start(18'h00010, 18'd1, t0);
        rx_byte(b, t1);
        chk("post_rst_hi", {24'd0, b}, 32'hA5);
        chk("post_rst_latency", t1 - t0, 5);
        rx_byte(b, td);
        chk("post_rst_lo", {24'd0, b}, 32'h5A);
        wait_done(td);
        chk("post_rst_done_time", td - t1, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
